// File: rtl/i2s_rx_deser.sv
// I2S receiver: oversamples bclk/lrclk/sdata on clk and deserialises each stereo frame
// into parallel left/right words, strobing sample_valid once per complete L/R pair.
module i2s_rx_deser #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bclk,
    input  logic             lrclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] left_sample,
    output logic [WIDTH-1:0] right_sample,
    output logic             sample_valid,
    output logic             frame_err,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic bclk_m, bclk_s, bclk_d;
    logic lr_m, lr_s, lr_prev;
    logic sd_m, sd_s;
    logic bclk_rise, lr_change;

    logic             channel;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    bitcnt;
    logic [WIDTH-1:0] left_hold;
    logic             left_hold_ok;

    logic shift_en, start_word, word_done, err_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_m <= 1'b0;
            bclk_s <= 1'b0;
            bclk_d <= 1'b0;
            lr_m   <= 1'b0;
            lr_s   <= 1'b0;
            sd_m   <= 1'b0;
            sd_s   <= 1'b0;
        end else begin
            bclk_m <= bclk;
            bclk_s <= bclk_m;
            bclk_d <= bclk_s;
            lr_m   <= lrclk;
            lr_s   <= lr_m;
            sd_m   <= sdata;
            sd_s   <= sd_m;
        end
    end

    assign bclk_rise = bclk_s & ~bclk_d;
    assign lr_change = bclk_rise & (lr_s ^ lr_prev);
    assign word      = {shreg[WIDTH-2:0], sd_s};
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // With exact-width slots the LSB arrives on the same rise that reveals the new
    // lrclk level, so a change at bitcnt == WIDTH-1 completes the word rather than erroring.
    always_comb begin
        state_nxt  = state;
        shift_en   = 1'b0;
        start_word = 1'b0;
        word_done  = 1'b0;
        err_pulse  = 1'b0;
        case (state)
            IDLE: begin
                if (lr_change) begin
                    start_word = 1'b1;
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                if (lr_change) begin
                    start_word = 1'b1;
                    if (bitcnt == LAST_BIT) begin
                        shift_en  = 1'b1;
                        word_done = 1'b1;
                    end else begin
                        err_pulse = 1'b1;
                    end
                end else if (bclk_rise) begin
                    shift_en = 1'b1;
                    if (bitcnt == LAST_BIT) begin
                        word_done = 1'b1;
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                if (lr_change) begin
                    start_word = 1'b1;
                    state_nxt  = SHIFT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // sample_valid is a bare strobe with no back-pressure: the downstream registers
    // must load left_sample/right_sample in the single cycle it is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            lr_prev      <= 1'b0;
            channel      <= 1'b0;
            shreg        <= '0;
            bitcnt       <= '0;
            left_hold    <= '0;
            left_hold_ok <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (bclk_rise) lr_prev <= lr_s;
            if (shift_en) begin
                shreg  <= word;
                bitcnt <= bitcnt + CW'(1);
            end
            if (start_word) begin
                bitcnt  <= '0;
                channel <= lr_s;
            end
            if (err_pulse) begin
                frame_err    <= 1'b1;
                left_hold_ok <= 1'b0;
            end
            if (word_done) begin
                if (!channel) begin
                    left_hold    <= word;
                    left_hold_ok <= 1'b1;
                end else if (left_hold_ok) begin
                    left_sample  <= left_hold;
                    right_sample <= word;
                    sample_valid <= 1'b1;
                    left_hold_ok <= 1'b0;
                end
            end
        end
    end

endmodule
